// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS EX stage: ALU, branch adder, dst select, iterative MULT with HI/LO; optional EX_FWD_EN forwarding
module ex_stage #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
`ifdef EX_FWD_EN
  input  logic [1:0]  fwd_a,
  input  logic [1:0]  fwd_b,
  input  logic [31:0] mem_fwd,
  input  logic [31:0] wb_fwd,
`endif
  input  logic [1:0]  WB_ctrl,
  input  logic [2:0]  Mem_ctrl,
  input  logic [3:0]  EX_ctrl,
  input  logic [31:0] EX_adder,
  input  logic [31:0] EX_ALU,
  input  logic [31:0] EXMux0_latch,
  input  logic [31:0] IR_out,
  input  logic [4:0]  EXMux0,
  input  logic [4:0]  EXMux1,
  output logic        stall,
  output logic [1:0]  exmem_wb,
  output logic [2:0]  exmem_m,
  output logic [31:0] exmem_target,
  output logic        exmem_zero,
  output logic [31:0] exmem_alu,
  output logic [31:0] exmem_wdata,
  output logic [4:0]  exmem_dst
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      mcand_q, mcand_d;
  logic [63:0]      acc_q, acc_d;
  logic [31:0]      mplier_q, mplier_d;
  logic             neg_q, neg_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;

  logic [1:0]       wb_q;
  logic [2:0]       m_q;
  logic [31:0]      target_q, alu_q, wdata_q;
  logic             zero_q;
  logic [4:0]       dst_q;

  logic [31:0]      op_a, op_b_reg, op_b, alu_res, a_mag, b_mag;
  logic [63:0]      acc_step, prod;
  logic             is_mult, reg_write_ok, bubble, stall_c;

`ifdef EX_FWD_EN
  // Forwarding muxes; 11 falls back to the register operand
  always_comb begin
    case (fwd_a)
      2'b10:   op_a = mem_fwd;
      2'b01:   op_a = wb_fwd;
      default: op_a = EX_ALU;
    endcase
    case (fwd_b)
      2'b10:   op_b_reg = mem_fwd;
      2'b01:   op_b_reg = wb_fwd;
      default: op_b_reg = EXMux0_latch;
    endcase
  end
`else
  assign op_a     = EX_ALU;
  assign op_b_reg = EXMux0_latch;
`endif

  assign op_b = EX_ctrl[0] ? IR_out : op_b_reg;

  // ALU control decode and ALU operation
  always_comb begin
    alu_res      = '0;
    reg_write_ok = 1'b1;
    is_mult      = 1'b0;
    case (EX_ctrl[2:1])
      2'b00, 2'b11: alu_res = op_a + op_b;
      2'b01:        alu_res = op_a - op_b;
      default: begin
        case (IR_out[5:0])
          6'h20:   alu_res = op_a + op_b;
          6'h22:   alu_res = op_a - op_b;
          6'h24:   alu_res = op_a & op_b;
          6'h25:   alu_res = op_a | op_b;
          6'h2A:   alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
          6'h18:   is_mult = 1'b1;
          6'h10:   alu_res = hi_q;
          6'h12:   alu_res = lo_q;
          default: reg_write_ok = 1'b0;
        endcase
      end
    endcase
  end

  assign a_mag    = op_a[31] ? (~op_a + 32'd1) : op_a;
  assign b_mag    = op_b_reg[31] ? (~op_b_reg + 32'd1) : op_b_reg;
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
  assign prod     = neg_q ? (~acc_step + 64'd1) : acc_step;

  // Multiplier FSM next state, datapath step and stall request
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    stall_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_mult && !flush) begin
          stall_c  = 1'b1;
          state_d  = S_MUL;
          mcand_d  = {32'b0, a_mag};
          mplier_d = b_mag;
          neg_d    = op_a[31] ^ op_b_reg[31];
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      S_MUL: begin
        stall_c = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          if (cnt_q == CNT_LAST) begin
            state_d = S_DONE;
            cnt_d   = '0;
            hi_d    = prod[63:32];
            lo_d    = prod[31:0];
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stall is suppressed while reset is held so the front end is free
  assign stall  = rst_n & stall_c;
  // MULT in any phase never reaches MEM/WB as a live instruction
  assign bubble = flush | (state_q != S_IDLE) | is_mult;

  // Multiplier and HI/LO state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // EX/MEM latch; control fields zeroed for bubbles, data always captured
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q     <= '0;
      m_q      <= '0;
      target_q <= '0;
      zero_q   <= 1'b0;
      alu_q    <= '0;
      wdata_q  <= '0;
      dst_q    <= '0;
    end else begin
      wb_q     <= bubble ? 2'b00 : {WB_ctrl[1] & reg_write_ok, WB_ctrl[0]};
      m_q      <= bubble ? 3'b000 : Mem_ctrl;
      dst_q    <= bubble ? 5'd0 : (EX_ctrl[3] ? EXMux1 : EXMux0);
      target_q <= EX_adder + (IR_out << 2);
      zero_q   <= (alu_res == 32'd0);
      alu_q    <= alu_res;
      wdata_q  <= op_b_reg;
    end
  end

  assign exmem_wb     = wb_q;
  assign exmem_m      = m_q;
  assign exmem_target = target_q;
  assign exmem_zero   = zero_q;
  assign exmem_alu    = alu_q;
  assign exmem_wdata  = wdata_q;
  assign exmem_dst    = dst_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed vector and multi-cycle MULT bench for ex_stage
module tb_ex_stage;

  logic        clk, rst_n, flush;
  logic [1:0]  WB_ctrl;
  logic [2:0]  Mem_ctrl;
  logic [3:0]  EX_ctrl;
  logic [31:0] EX_adder, EX_ALU, EXMux0_latch, IR_out;
  logic [4:0]  EXMux0, EXMux1;
  logic        stall;
  logic [1:0]  exmem_wb;
  logic [2:0]  exmem_m;
  logic [31:0] exmem_target, exmem_alu, exmem_wdata;
  logic        exmem_zero;
  logic [4:0]  exmem_dst;
`ifdef EX_FWD_EN
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] mem_fwd, wb_fwd;
  assign fwd_a   = 2'b00;
  assign fwd_b   = 2'b00;
  assign mem_fwd = 32'hDEAD_0001;
  assign wb_fwd  = 32'hDEAD_0002;
`endif

  int checks   = 0;
  int failures = 0;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
`ifdef EX_FWD_EN
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_fwd(mem_fwd), .wb_fwd(wb_fwd),
`endif
    .WB_ctrl(WB_ctrl), .Mem_ctrl(Mem_ctrl), .EX_ctrl(EX_ctrl),
    .EX_adder(EX_adder), .EX_ALU(EX_ALU), .EXMux0_latch(EXMux0_latch),
    .IR_out(IR_out), .EXMux0(EXMux0), .EXMux1(EXMux1), .stall(stall),
    .exmem_wb(exmem_wb), .exmem_m(exmem_m), .exmem_target(exmem_target),
    .exmem_zero(exmem_zero), .exmem_alu(exmem_alu), .exmem_wdata(exmem_wdata),
    .exmem_dst(exmem_dst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wb;   logic [2:0]  m;    logic [3:0] ex;
    logic [31:0] pc;   logic [31:0] rs;   logic [31:0] rt;  logic [31:0] imm;
    logic [4:0]  rtn;  logic [4:0]  rdn;  logic       fl;
    logic [1:0]  e_wb; logic [2:0]  e_m;  logic [31:0] e_tgt; logic e_zero;
    logic [31:0] e_alu; logic [31:0] e_wdata; logic [4:0] e_dst;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
                         input logic [31:0] pc, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] imm, input logic [4:0] rtn, input logic [4:0] rdn,
                         input logic fl, input logic [1:0] e_wb, input logic [2:0] e_m,
                         input logic [31:0] e_tgt, input logic e_zero, input logic [31:0] e_alu,
                         input logic [31:0] e_wdata, input logic [4:0] e_dst);
    vec_t v;
    v.wb = wb; v.m = m; v.ex = ex; v.pc = pc; v.rs = rs; v.rt = rt; v.imm = imm;
    v.rtn = rtn; v.rdn = rdn; v.fl = fl; v.e_wb = e_wb; v.e_m = e_m; v.e_tgt = e_tgt;
    v.e_zero = e_zero; v.e_alu = e_alu; v.e_wdata = e_wdata; v.e_dst = e_dst;
    vecs.push_back(v);
  endtask

  task automatic set_in(input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
                        input logic [31:0] pc, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] imm, input logic [4:0] rtn, input logic [4:0] rdn,
                        input logic fl);
    WB_ctrl = wb; Mem_ctrl = m; EX_ctrl = ex; EX_adder = pc; EX_ALU = rs;
    EXMux0_latch = rt; IR_out = imm; EXMux0 = rtn; EXMux1 = rdn; flush = fl;
  endtask

  // R-type with RegWrite=1, RegDst=1, ALUOp=10
  task automatic r_type(input logic [5:0] funct, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [4:0] rd);
    set_in(2'b10, 3'b000, 4'b1100, 32'h0, rs, rt, {26'b0, funct}, 5'd1, rd, 1'b0);
  endtask

  task automatic chk_bubble(input string name);
    chk({name, "_wb"}, {62'b0, exmem_wb}, 64'd0);
    chk({name, "_m"}, {61'b0, exmem_m}, 64'd0);
    chk({name, "_dst"}, {59'b0, exmem_dst}, 64'd0);
  endtask

  // Issue MFHI/MFLO and check the value moved to EX/MEM on the next edge
  task automatic mfx(input string name, input logic [5:0] funct, input logic [31:0] exp);
    r_type(funct, 32'h0, 32'h0, 5'd9);
    @(posedge clk); #1;
    chk({name, "_alu"}, {32'b0, exmem_alu}, {32'b0, exp});
    chk({name, "_wb"}, {62'b0, exmem_wb}, 64'd2);
    chk({name, "_dst"}, {59'b0, exmem_dst}, 64'd9);
  endtask

  // Full MULT: counts stall cycles, checks bubbles, and lets DONE consume it
  task automatic run_mult(input string name, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    r_type(6'h18, a, b, 5'd4);
    for (int k = 0; k < 60; k++) begin
      #1;
      if (!stall) break;
      n++;
      @(posedge clk); #1;
      chk_bubble($sformatf("%s_stallcyc%0d", name, n));
    end
    chk({name, "_stall_cycles"}, 64'(n), 64'd33);
    @(posedge clk); #1;
    chk_bubble({name, "_done"});
  endtask

  initial begin
    rst_n = 1'b1;
    r_type(6'h18, 32'd5, 32'd6, 5'd4);
    #1 rst_n = 1'b0;

    // Reset with a MULT presented: outputs clear and no stall
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", {63'b0, stall}, 64'd0);
    chk("rst_target", {32'b0, exmem_target}, 64'd0);
    chk("rst_wdata", {32'b0, exmem_wdata}, 64'd0);
    chk_bubble("rst");
    set_in(2'b00, 3'b000, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    add_vec(2'b10,3'b000,4'b1100,32'h0,32'd7,32'd5,32'h20,5'd2,5'd3,1'b0,
            2'b10,3'b000,32'h80,1'b0,32'd12,32'd5,5'd3);
    add_vec(2'b00,3'b100,4'b0010,32'h100,32'd9,32'd9,32'd4,5'd9,5'd0,1'b0,
            2'b00,3'b100,32'h110,1'b1,32'd0,32'd9,5'd9);
    add_vec(2'b10,3'b000,4'b1100,32'h40,32'hFFFFFFFF,32'd1,32'h2A,5'd1,5'd8,1'b0,
            2'b10,3'b000,32'hE8,1'b0,32'd1,32'd1,5'd8);
    add_vec(2'b11,3'b010,4'b0001,32'h200,32'h1000,32'h55,32'hFFFFFFFC,5'd4,5'd0,1'b0,
            2'b11,3'b010,32'h1F0,1'b0,32'hFFC,32'h55,5'd4);
    add_vec(2'b10,3'b000,4'b1100,32'h0,32'd5,32'd5,32'h22,5'd7,5'd6,1'b0,
            2'b10,3'b000,32'h88,1'b1,32'd0,32'd5,5'd6);
    add_vec(2'b10,3'b000,4'b1100,32'h0,32'hF0F0,32'hFF00,32'h24,5'd11,5'd10,1'b0,
            2'b10,3'b000,32'h90,1'b0,32'hF000,32'hFF00,5'd10);
    add_vec(2'b10,3'b000,4'b1100,32'h0,32'hF0F0,32'h0F0F,32'h25,5'd11,5'd10,1'b0,
            2'b10,3'b000,32'h94,1'b0,32'hFFFF,32'h0F0F,5'd10);
    add_vec(2'b10,3'b000,4'b1100,32'h0,32'd1,32'd2,32'h3F,5'd13,5'd12,1'b0,
            2'b00,3'b000,32'hFC,1'b1,32'd0,32'd2,5'd12);
    add_vec(2'b10,3'b001,4'b1100,32'h10,32'd1,32'd1,32'h20,5'd2,5'd3,1'b1,
            2'b00,3'b000,32'h90,1'b0,32'd2,32'd1,5'd0);
    add_vec(2'b00,3'b100,4'b0010,32'h104,32'd0,32'd1,32'hFFFFFFFF,5'd1,5'd0,1'b0,
            2'b00,3'b100,32'h100,1'b0,32'hFFFFFFFF,32'd1,5'd1);
    add_vec(2'b10,3'b000,4'b0111,32'h0,32'hFFFFFFFF,32'd7,32'd2,5'd2,5'd0,1'b0,
            2'b10,3'b000,32'h8,1'b0,32'd1,32'd7,5'd2);
    add_vec(2'b10,3'b000,4'b1100,32'h0,32'd1,32'hFFFFFFFF,32'h2A,5'd1,5'd5,1'b0,
            2'b10,3'b000,32'hA8,1'b1,32'd0,32'hFFFFFFFF,5'd5);
    add_vec(2'b11,3'b000,4'b1100,32'h0,32'd3,32'd4,32'h00,5'd1,5'd2,1'b0,
            2'b01,3'b000,32'h0,1'b1,32'd0,32'd4,5'd2);

    foreach (vecs[i]) begin
      set_in(vecs[i].wb, vecs[i].m, vecs[i].ex, vecs[i].pc, vecs[i].rs, vecs[i].rt,
             vecs[i].imm, vecs[i].rtn, vecs[i].rdn, vecs[i].fl);
      #1;
      chk($sformatf("v%0d_stall", i), {63'b0, stall}, 64'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_wb", i), {62'b0, exmem_wb}, {62'b0, vecs[i].e_wb});
      chk($sformatf("v%0d_m", i), {61'b0, exmem_m}, {61'b0, vecs[i].e_m});
      chk($sformatf("v%0d_target", i), {32'b0, exmem_target}, {32'b0, vecs[i].e_tgt});
      chk($sformatf("v%0d_zero", i), {63'b0, exmem_zero}, {63'b0, vecs[i].e_zero});
      chk($sformatf("v%0d_alu", i), {32'b0, exmem_alu}, {32'b0, vecs[i].e_alu});
      chk($sformatf("v%0d_wdata", i), {32'b0, exmem_wdata}, {32'b0, vecs[i].e_wdata});
      chk($sformatf("v%0d_dst", i), {59'b0, exmem_dst}, {59'b0, vecs[i].e_dst});
    end

    // HI/LO cleared by reset
    mfx("rst_mfhi", 6'h10, 32'h0);
    mfx("rst_mflo", 6'h12, 32'h0);

    // -3 * 7 = -21
    run_mult("mult_m3x7", 32'hFFFFFFFD, 32'd7);
    mfx("mflo_m21", 6'h12, 32'hFFFFFFEB);
    mfx("mfhi_m21", 6'h10, 32'hFFFFFFFF);

    // Flush ten cycles into a MULT: abort, HI/LO untouched
    r_type(6'h18, 32'd5, 32'd6, 5'd4);
    #1 chk("fl_stall0", {63'b0, stall}, 64'd1);
    repeat (10) @(posedge clk);
    #1 chk("fl_stall10", {63'b0, stall}, 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    r_type(6'h12, 32'h0, 32'h0, 5'd9);
    #1;
    chk("fl_stall_after", {63'b0, stall}, 64'd0);
    chk_bubble("fl_capture");
    @(posedge clk); #1;
    chk("fl_mflo_alu", {32'b0, exmem_alu}, 64'hFFFFFFEB);
    mfx("fl_mfhi", 6'h10, 32'hFFFFFFFF);

    // Most negative multiplicand; positive product; negative multiplier
    run_mult("mult_min_x2", 32'h80000000, 32'd2);
    mfx("mfhi_min", 6'h10, 32'hFFFFFFFF);
    mfx("mflo_min", 6'h12, 32'h0);
    run_mult("mult_5x6", 32'd5, 32'd6);
    mfx("mflo_30", 6'h12, 32'd30);
    mfx("mfhi_30", 6'h10, 32'h0);
    run_mult("mult_7xm3", 32'd7, 32'hFFFFFFFD);
    mfx("mflo_m21b", 6'h12, 32'hFFFFFFEB);
    mfx("mfhi_m21b", 6'h10, 32'hFFFFFFFF);

    // Asynchronous reset in the middle of a MULT
    r_type(6'h18, 32'd5, 32'd6, 5'd4);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mrst_stall", {63'b0, stall}, 64'd0);
    chk("mrst_target", {32'b0, exmem_target}, 64'd0);
    chk("mrst_wdata", {32'b0, exmem_wdata}, 64'd0);
    chk("mrst_zero", {63'b0, exmem_zero}, 64'd0);
    chk_bubble("mrst");
    r_type(6'h12, 32'h0, 32'h0, 5'd9);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mrst_mflo", {32'b0, exmem_alu}, 64'd0);
    mfx("mrst_mfhi", 6'h10, 32'h0);
    r_type(6'h20, 32'd7, 32'd5, 5'd3);
    @(posedge clk); #1;
    chk("mrst_add_alu", {32'b0, exmem_alu}, 64'd12);
    chk("mrst_add_dst", {59'b0, exmem_dst}, 64'd3);
    chk("mrst_add_wb", {62'b0, exmem_wb}, 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
